// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch responder.
// Queue entry and registered response layouts.
package ifetch_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h00000013;

  typedef struct packed {
    logic slot_hi;
    logic err;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [63:0] inst;
  } resp_t;

endpackage

// File: rtl/ifetch_req_fifo.sv
// Synchronous request FIFO with single-cycle clear.
// Pointers carry one extra bit to tell full from empty.
module ifetch_req_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  fetch_entry_t mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifetch_responder.sv
// Fetch-port responder: queues core fetch requests and answers each
// with one externally sourced instruction placed in the pc[2] slot.
module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = NOP_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       mem_i_rd_i,
  input  logic                       mem_i_flush_i,
  input  logic                       mem_i_invalidate_i,
  input  logic [31:0]                mem_i_pc_i,
  output logic                       mem_i_accept_o,
  output logic                       mem_i_valid_o,
  output logic                       mem_i_error_o,
  output logic [63:0]                mem_i_inst_o,
  input  logic                       src_valid_i,
  input  logic [31:0]                src_inst_i,
  output logic                       src_ready_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic [CNT_W-1:0]           resp_cnt_o
);

  logic         flush_w;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         head_ok;
  logic         err_pop;
  logic         src_pop;
  fetch_entry_t wentry;
  fetch_entry_t head;
  resp_t        resp_q;
  resp_t        resp_d;
  logic [CNT_W-1:0] cnt_q;

  assign flush_w = mem_i_flush_i | mem_i_invalidate_i;

  // Held low in reset so the core never sees an accept before the queue exists
  assign mem_i_accept_o = rst_ni & ~full & ~flush_w;
  assign push = mem_i_rd_i & mem_i_accept_o;

  assign wentry.slot_hi = mem_i_pc_i[2];
  assign wentry.err     = |mem_i_pc_i[1:0];

  assign head_ok     = ~empty & ~flush_w;
  assign err_pop     = head_ok & head.err;
  assign src_ready_o = head_ok & ~head.err;
  assign src_pop     = src_ready_o & src_valid_i;
  assign pop         = err_pop | src_pop;

  ifetch_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (wentry),
    .pop    (pop),
    .clear  (flush_w),
    .full   (full),
    .empty  (empty),
    .count  (outstanding_o),
    .head   (head)
  );

  always_comb begin
    resp_d       = resp_q;
    resp_d.valid = pop;
    resp_d.error = err_pop;
    if (src_pop) begin
      resp_d.inst = head.slot_hi ? {src_inst_i, NOP_INST}
                                 : {NOP_INST, src_inst_i};
    end else if (err_pop) begin
      resp_d.inst = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
      cnt_q  <= '0;
    end else begin
      resp_q <= resp_d;
      if (src_pop && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign mem_i_valid_o = resp_q.valid;
  assign mem_i_error_o = resp_q.error;
  assign mem_i_inst_o  = resp_q.inst;
  assign resp_cnt_o    = cnt_q;

endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder.
// Scoreboard queue filled on accepted requests, drained on responses.
module tb_ifetch_responder;

  localparam int          DEPTH = 4;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    logic        err;
    logic [63:0] inst;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        mem_i_rd_i;
  logic        mem_i_flush_i;
  logic        mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o;
  logic        mem_i_valid_o;
  logic        mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic        src_valid_i;
  logic [31:0] src_inst_i;
  logic        src_ready_o;
  logic [2:0]  outstanding_o;
  logic [CNT_W-1:0] resp_cnt_o;

  exp_t        q[$];
  logic [31:0] words[256];
  int          nw;
  int          feed_idx;
  int          assign_idx;
  bit          src_en;
  bit          force_src;
  bit          took_src;
  int          nvalid;
  logic [CNT_W-1:0] exp_cnt;
  int          total;
  int          bad;

  ifetch_responder #(
    .DEPTH    (DEPTH),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .mem_i_rd_i         (mem_i_rd_i),
    .mem_i_flush_i      (mem_i_flush_i),
    .mem_i_invalidate_i (mem_i_invalidate_i),
    .mem_i_pc_i         (mem_i_pc_i),
    .mem_i_accept_o     (mem_i_accept_o),
    .mem_i_valid_o      (mem_i_valid_o),
    .mem_i_error_o      (mem_i_error_o),
    .mem_i_inst_o       (mem_i_inst_o),
    .src_valid_i        (src_valid_i),
    .src_inst_i         (src_inst_i),
    .src_ready_o        (src_ready_o),
    .outstanding_o      (outstanding_o),
    .resp_cnt_o         (resp_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic drive_src();
    src_valid_i = force_src || (src_en && (feed_idx < nw));
    src_inst_i  = (feed_idx < nw) ? words[feed_idx] : 32'hdeadbeef;
  endtask

  task automatic load(input logic [31:0] w);
    words[nw] = w;
    nw++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // Request side: record what each accepted request must produce
  always @(negedge clk_i) begin
    exp_t e;
    logic [31:0] w;
    took_src = 1'b0;
    if (!rst_ni) begin
      q.delete();
      assign_idx = feed_idx;
      exp_cnt = '0;
    end else if (mem_i_flush_i || mem_i_invalidate_i) begin
      q.delete();
      assign_idx = feed_idx;
    end else begin
      if (mem_i_rd_i && mem_i_accept_o) begin
        if (mem_i_pc_i[1:0] != 2'b00) begin
          e.err  = 1'b1;
          e.inst = 64'h0;
        end else begin
          w = words[assign_idx];
          assign_idx++;
          e.err  = 1'b0;
          e.inst = mem_i_pc_i[2] ? {w, NOP} : {NOP, w};
        end
        q.push_back(e);
      end
      took_src = src_ready_o && src_valid_i;
    end
  end

  // Response side: compare each valid pulse with the queue head
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (rst_ni) begin
      if (took_src) feed_idx++;
      if (mem_i_valid_o) begin
        nvalid++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp got=valid err=%0b inst=%h exp=none",
                   mem_i_error_o, mem_i_inst_o);
        end else begin
          e = q.pop_front();
          if (mem_i_error_o !== e.err || mem_i_inst_o !== e.inst) begin
            bad++;
            $display("FAIL resp_data got=%0b/%h exp=%0b/%h",
                     mem_i_error_o, mem_i_inst_o, e.err, e.inst);
          end
          if (!e.err && exp_cnt != '1) exp_cnt++;
          total++;
          if (resp_cnt_o !== exp_cnt) begin
            bad++;
            $display("FAIL resp_cnt got=%0d exp=%0d", resp_cnt_o, exp_cnt);
          end
        end
      end
    end
    drive_src();
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    mem_i_rd_i = 1'b1;
    mem_i_flush_i = 1'b0;
    mem_i_invalidate_i = 1'b0;
    mem_i_pc_i = 32'h80000000;
    drive_src();
    #1;
    total++;
    if ({mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
         src_ready_o, outstanding_o, resp_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0b%0b%0b %h %0b %0d %0d exp=all_zero",
               mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
               src_ready_o, outstanding_o, resp_cnt_o);
    end
    repeat (3) step();
    mem_i_rd_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    total++;
    if (mem_i_accept_o !== 1'b1 || outstanding_o !== 3'd0 ||
        mem_i_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got=acc%0b out%0d v%0b exp=acc1 out0 v0",
               mem_i_accept_o, outstanding_o, mem_i_valid_o);
    end
  endtask

  task automatic test_single();
    load(32'h00100093);
    src_en = 1'b1;
    drive_src();
    mem_i_pc_i = 32'h80000000;
    mem_i_rd_i = 1'b1;
    step();
    mem_i_rd_i = 1'b0;
    total++;
    if (mem_i_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_n1 got=%0b exp=0", mem_i_valid_o);
    end
    step();
    total++;
    if (mem_i_valid_o !== 1'b1 || mem_i_error_o !== 1'b0 ||
        mem_i_inst_o !== 64'h00000013_00100093 || resp_cnt_o !== 4'd1) begin
      bad++;
      $display("FAIL single_n2 got=%0b %0b %h %0d exp=1 0 0000001300100093 1",
               mem_i_valid_o, mem_i_error_o, mem_i_inst_o, resp_cnt_o);
    end
  endtask

  task automatic test_hi_slot();
    load(32'h00208113);
    drive_src();
    mem_i_pc_i = 32'h80000004;
    mem_i_rd_i = 1'b1;
    step();
    mem_i_rd_i = 1'b0;
    step();
    total++;
    if (mem_i_valid_o !== 1'b1 || mem_i_inst_o !== 64'h00208113_00000013 ||
        resp_cnt_o !== 4'd2) begin
      bad++;
      $display("FAIL hi_slot got=%0b %h %0d exp=1 0020811300000013 2",
               mem_i_valid_o, mem_i_inst_o, resp_cnt_o);
    end
    step();
    total++;
    if (mem_i_valid_o !== 1'b0 || mem_i_inst_o !== 64'h00208113_00000013) begin
      bad++;
      $display("FAIL hold_inst got=%0b %h exp=0 0020811300000013",
               mem_i_valid_o, mem_i_inst_o);
    end
  endtask

  task automatic test_error();
    int f0;
    f0 = feed_idx;
    force_src = 1'b1;
    drive_src();
    mem_i_pc_i = 32'h80000002;
    mem_i_rd_i = 1'b1;
    step();
    mem_i_rd_i = 1'b0;
    total++;
    if (src_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL err_src_ready got=%0b exp=0", src_ready_o);
    end
    step();
    total++;
    if (mem_i_valid_o !== 1'b1 || mem_i_error_o !== 1'b1 ||
        mem_i_inst_o !== 64'h0 || resp_cnt_o !== 4'd2) begin
      bad++;
      $display("FAIL err_resp got=%0b %0b %h %0d exp=1 1 0 2",
               mem_i_valid_o, mem_i_error_o, mem_i_inst_o, resp_cnt_o);
    end
    force_src = 1'b0;
    drive_src();
    step();
    total++;
    if (mem_i_valid_o !== 1'b0 || mem_i_error_o !== 1'b0 || feed_idx != f0) begin
      bad++;
      $display("FAIL err_after got=%0b %0b fed%0d exp=0 0 fed%0d",
               mem_i_valid_o, mem_i_error_o, feed_idx, f0);
    end
  endtask

  task automatic test_full();
    int v0;
    src_en = 1'b0;
    drive_src();
    for (int i = 0; i < 4; i++) load(32'h00a00093 + (i << 20));
    for (int i = 0; i < 5; i++) begin
      mem_i_pc_i = 32'h00000100 + i * 4;
      mem_i_rd_i = 1'b1;
      #1;
      total++;
      if (mem_i_accept_o !== (i < 4)) begin
        bad++;
        $display("FAIL full_accept[%0d] got=%0b exp=%0b",
                 i, mem_i_accept_o, i < 4);
      end
      step();
    end
    mem_i_rd_i = 1'b0;
    total++;
    if (outstanding_o !== 3'd4) begin
      bad++;
      $display("FAIL full_count got=%0d exp=4", outstanding_o);
    end
    v0 = nvalid;
    src_en = 1'b1;
    drive_src();
    mem_i_pc_i = 32'h00000200;
    mem_i_rd_i = 1'b1;
    #1;
    total++;
    if (mem_i_accept_o !== 1'b0 || src_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_push got=acc%0b rdy%0b exp=acc0 rdy1",
               mem_i_accept_o, src_ready_o);
    end
    step();
    mem_i_rd_i = 1'b0;
    for (int k = 0; k < 3; k++) step();
    total++;
    if (mem_i_valid_o !== 1'b1 || nvalid - v0 != 4) begin
      bad++;
      $display("FAIL full_drain got=v%0b n%0d exp=v1 n4",
               mem_i_valid_o, nvalid - v0);
    end
    step();
    total++;
    if (mem_i_valid_o !== 1'b0 || outstanding_o !== 3'd0) begin
      bad++;
      $display("FAIL full_empty got=v%0b out%0d exp=v0 out0",
               mem_i_valid_o, outstanding_o);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    int k;
    v0 = nvalid;
    for (int i = 0; i < 6; i++) load(32'h00300013 + (i << 15));
    src_en = 1'b1;
    drive_src();
    for (int i = 0; i < 6; i++) begin
      mem_i_pc_i = 32'h00000300 + i * 4;
      mem_i_rd_i = 1'b1;
      step();
      total++;
      if (outstanding_o !== 3'd1) begin
        bad++;
        $display("FAIL b2b_count[%0d] got=%0d exp=1", i, outstanding_o);
      end
    end
    mem_i_rd_i = 1'b0;
    k = 0;
    while ((q.size() != 0 || outstanding_o != 0) && k < 20) begin
      step();
      k++;
    end
    total++;
    if (nvalid - v0 != 6 || k >= 20) begin
      bad++;
      $display("FAIL b2b_resps got=%0d exp=6", nvalid - v0);
    end
  endtask

  task automatic test_flush();
    int v0;
    int f0;
    src_en = 1'b0;
    drive_src();
    for (int i = 0; i < 3; i++) load(32'h00500093 + (i << 20));
    for (int i = 0; i < 3; i++) begin
      mem_i_pc_i = 32'h00000400 + i * 4;
      mem_i_rd_i = 1'b1;
      step();
    end
    v0 = nvalid;
    f0 = feed_idx;
    src_en = 1'b1;
    drive_src();
    mem_i_pc_i = 32'h0000040c;
    mem_i_flush_i = 1'b1;
    #1;
    total++;
    if (mem_i_accept_o !== 1'b0 || src_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_gate got=acc%0b rdy%0b exp=acc0 rdy0",
               mem_i_accept_o, src_ready_o);
    end
    step();
    mem_i_flush_i = 1'b0;
    mem_i_rd_i = 1'b0;
    total++;
    if (outstanding_o !== 3'd0 || mem_i_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear got=out%0d v%0b exp=out0 v0",
               outstanding_o, mem_i_valid_o);
    end
    repeat (3) step();
    total++;
    if (nvalid != v0 || feed_idx != f0) begin
      bad++;
      $display("FAIL flush_quiet got=n%0d fed%0d exp=n%0d fed%0d",
               nvalid, feed_idx, v0, f0);
    end
    mem_i_pc_i = 32'h00000500;
    mem_i_rd_i = 1'b1;
    #1;
    total++;
    if (mem_i_accept_o !== 1'b1) begin
      bad++;
      $display("FAIL after_flush_acc got=%0b exp=1", mem_i_accept_o);
    end
    step();
    mem_i_rd_i = 1'b0;
    step();
    total++;
    if (mem_i_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL after_flush_resp got=%0b exp=1", mem_i_valid_o);
    end
    src_en = 1'b0;
    drive_src();
    mem_i_pc_i = 32'h00000504;
    mem_i_rd_i = 1'b1;
    step();
    mem_i_rd_i = 1'b0;
    mem_i_invalidate_i = 1'b1;
    step();
    mem_i_invalidate_i = 1'b0;
    total++;
    if (outstanding_o !== 3'd0) begin
      bad++;
      $display("FAIL invalidate got=%0d exp=0", outstanding_o);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    src_en = 1'b0;
    drive_src();
    for (int i = 0; i < 3; i++) load(32'h00700093 + (i << 20));
    for (int i = 0; i < 3; i++) begin
      mem_i_pc_i = 32'h00000600 + i * 4;
      mem_i_rd_i = 1'b1;
      step();
    end
    mem_i_rd_i = 1'b0;
    src_en = 1'b1;
    drive_src();
    step();
    total++;
    if (mem_i_valid_o !== 1'b1 || outstanding_o !== 3'd2) begin
      bad++;
      $display("FAIL pre_reset got=v%0b out%0d exp=v1 out2",
               mem_i_valid_o, outstanding_o);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
         src_ready_o, outstanding_o, resp_cnt_o} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%0b%0b%0b %h %0b %0d %0d exp=all_zero",
               mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
               src_ready_o, outstanding_o, resp_cnt_o);
    end
    step();
    step();
    rst_ni = 1'b1;
    v0 = nvalid;
    repeat (5) step();
    total++;
    if (nvalid != v0 || outstanding_o !== 3'd0) begin
      bad++;
      $display("FAIL late_valid got=n%0d out%0d exp=n%0d out0",
               nvalid, outstanding_o, v0);
    end
  endtask

  task automatic test_saturate();
    int k;
    for (int i = 0; i < 20; i++) load(32'h00900013 + (i << 7));
    src_en = 1'b1;
    drive_src();
    for (int i = 0; i < 20; i++) begin
      mem_i_pc_i = 32'h00000700 + i * 4;
      mem_i_rd_i = 1'b1;
      step();
    end
    mem_i_rd_i = 1'b0;
    k = 0;
    while ((q.size() != 0 || outstanding_o != 0) && k < 20) begin
      step();
      k++;
    end
    total++;
    if (resp_cnt_o !== 4'hf || k >= 20) begin
      bad++;
      $display("FAIL saturate got=%0d exp=15", resp_cnt_o);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    nw = 0;
    feed_idx = 0;
    assign_idx = 0;
    src_en = 1'b0;
    force_src = 1'b0;
    nvalid = 0;
    exp_cnt = '0;
    test_reset();
    step();
    test_single();
    test_hi_slot();
    test_error();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturate();
    step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
- Responder side of the core instruction-fetch port. Accepts fetch requests (rd/pc) from riscv_core and returns 64-bit instruction responses (valid/error/inst).
- Instruction words come from an external 32-bit valid/ready source (QED module or formal cutpoint), not from memory.
- Each response carries one source instruction in the 32-bit slot selected by pc[2]; the other slot is NOP.
- Sits between the instruction source and riscv_core in formal/QED harness tops. Replaces tcm_mem's fetch side and the ad-hoc stall_IF register.

Parameters:
- DEPTH, 4, max outstanding fetch requests; power of 2, at least 2.
- NOP_INST, 32'h00000013, filler word for the unused slot.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous assert, active-low
- mem_i_rd_i  in  1  fetch request strobe
- mem_i_flush_i  in  1  flush; discard all outstanding requests
- mem_i_invalidate_i  in  1  treated identically to flush
- mem_i_pc_i  in  32  fetch address
- mem_i_accept_o  out  1  request accepted this cycle if mem_i_rd_i is also high
- mem_i_valid_o  out  1  response valid, single-cycle pulse per response
- mem_i_error_o  out  1  response is an error (misaligned pc)
- mem_i_inst_o  out  64  response instruction pair
- src_valid_i  in  1  source instruction available
- src_inst_i  in  32  source instruction
- src_ready_o  out  1  source word consumed when src_valid_i is also high
- outstanding_o  out  $clog2(DEPTH+1)  queued, unanswered requests
- resp_cnt_o  out  CNT_W  non-error responses delivered, saturating

Behaviour:
- Reset (rst_ni low, asynchronous): FIFO empty.
  - mem_i_valid_o=0, mem_i_error_o=0, mem_i_inst_o=0.
  - mem_i_accept_o=0 while in reset; src_ready_o=0; outstanding_o=0; resp_cnt_o=0.
  - Reset mid-operation drops every queued request; no response is ever produced for it.
- flush_w = mem_i_flush_i | mem_i_invalidate_i.
- Accept: mem_i_accept_o = !full & !flush_w. This is combinational.
  - A request is taken when mem_i_rd_i & mem_i_accept_o.
  - The FIFO stores {pc[2], err}, where err = (pc[1:0] != 0).
- Head processing: the head entry is visible the cycle after push (no bypass).
- Error head: pop it and register a response next edge with valid=1, error=1, inst=0. The source is not consumed.
- Normal head:
  - src_ready_o = head_valid & !head_err & !flush_w.
  - On the src handshake: pop, and register valid=1, error=0.
  - inst = pc[2] ? {src_inst_i, NOP_INST} : {NOP_INST, src_inst_i}.
- Minimum latency: accept at cycle N, response valid at N+2. Throughput is one response per cycle.
- mem_i_valid_o and mem_i_error_o deassert the cycle after a pulse unless another pop occurs.
- mem_i_inst_o holds its last value when not valid.
- Flush/invalidate cycle:
  - All FIFO entries are discarded.
  - Any response being registered that edge is suppressed; valid is 0 the next cycle.
  - src_ready_o=0, so the source word is not consumed.
  - A request coinciding with flush is not accepted.
  - A request in the cycle after flush is accepted normally.
- Full: with DEPTH entries queued, accept=0. A pop that cycle does not enable push the same cycle (no simultaneous pop-push when full).
- Empty: src_ready_o=0, no response.
- Simultaneous push and pop when not full: both occur; outstanding_o is unchanged.
- Pointers wrap modulo DEPTH, with one extra bit for full/empty.
- resp_cnt_o increments on each non-error response and saturates at all-ones.

Decomposition:
- Package ifetch_pkg holds:
  - NOP_INST default constant;
  - fetch-entry typedef {slot_hi, err};
  - response typedef {valid, error, inst[63:0]}.
- Sub-module ifetch_req_fifo holds the synchronous FIFO with clear. Its ports are push/pop/clear/full/empty/count/head.

Test Plan:
- Single request pc=0x80000000, src_valid=1 with 0x00100093 → at N+2: valid=1, error=0, inst=0x00000013_00100093, resp_cnt=1.
- pc=0x80000004, src word 0x00208113 → inst=0x00208113_00000013.
- pc=0x80000002 → error pulse at N+2, inst=0, src_ready never asserted for it, resp_cnt unchanged.
- 5 back-to-back requests with src_valid=0 → first 4 accepted, accept=0 on the 5th, outstanding=4. Then src_valid=1 → 4 consecutive valid pulses in order.
- Queue 3 requests, then assert mem_i_flush_i for one cycle alongside rd → no responses, outstanding=0, the coincident rd is not accepted, no source word consumed.
- Deassert rst_ni with 2 requests outstanding and a response pending → all outputs 0 immediately, asynchronous to clk_i, and no late valid after release.
